// File: rtl/ir_ctrl_if.sv
// Bus between the instruction register control
// and the PC, instruction memory, ALU and data memory.
interface ir_ctrl_if;
  logic [4:0] adpc;
  logic [7:0] imem_data;
  logic       acc_zero;
  logic       resume;
  logic [4:0] adir;
  logic       ldpc;
  logic [7:0] ir;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       exec_valid;
  logic       acc_ld;
  logic       mem_wr;
  logic       halted;

  modport master (
    output adpc, imem_data, acc_zero, resume,
    input  adir, ldpc, ir, opcode, operand,
    input  exec_valid, acc_ld, mem_wr, halted
  );

  modport slave (
    input  adpc, imem_data, acc_zero, resume,
    output adir, ldpc, ir, opcode, operand,
    output exec_valid, acc_ld, mem_wr, halted
  );
endinterface

// File: rtl/ir_ctrl.sv
// Instruction register and sequencing control:
// latches fetches, squashes wrong-path slots, drives PC loads.
module ir_ctrl (
  input logic     pclk,
  input logic     rst,
  ir_ctrl_if.slave bus
);
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] ir_q;
  logic       ev_q;
  logic [4:0] halt_addr;

  logic [2:0] op;
  logic       live;
  logic       is_jmp;
  logic       is_hlt;
  logic       is_skz_t;
  logic       squash;
  logic       ldpc_c;
  logic [4:0] adir_c;

  assign op       = ir_q[7:5];
  assign live     = ev_q && (state == RUN);
  assign is_jmp   = live && (op == OP_JMP);
  assign is_hlt   = live && (op == OP_HLT);
  assign is_skz_t = live && (op == OP_SKZ)
                    && bus.acc_zero;
  assign squash   = is_jmp || is_hlt || is_skz_t;

  // PC load select: halt hold, jump, or halt entry
  always_comb begin
    ldpc_c = 1'b0;
    adir_c = '0;
    unique case (1'b1)
      (state == HALTED): begin
        ldpc_c = !bus.resume;
        adir_c = bus.resume ? 5'd0 : halt_addr;
      end
      is_jmp: begin
        ldpc_c = 1'b1;
        adir_c = ir_q[4:0];
      end
      is_hlt: begin
        ldpc_c = 1'b1;
        adir_c = bus.adpc;
      end
      default: ;
    endcase
  end

  // Fetch latch, squash tracking and run/halt sequencing
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      ir_q      <= '0;
      ev_q      <= 1'b0;
      halt_addr <= '0;
    end else begin
      unique case (state)
        RUN: begin
          ir_q <= bus.imem_data;
          ev_q <= !squash;
          if (is_hlt) begin
            halt_addr <= bus.adpc;
            state     <= HALTED;
          end
        end
        HALTED: begin
          if (bus.resume) begin
            ir_q  <= bus.imem_data;
            ev_q  <= 1'b1;
            state <= RUN;
          end else begin
            ev_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.ir         = ir_q;
  assign bus.opcode     = op;
  assign bus.operand    = ir_q[4:0];
  assign bus.exec_valid = ev_q;
  assign bus.halted     = (state == HALTED);
  assign bus.ldpc       = ldpc_c;
  assign bus.adir       = adir_c;
  assign bus.acc_ld     = live &&
                          ((op == OP_ADD) ||
                           (op == OP_AND) ||
                           (op == OP_XOR) ||
                           (op == OP_LDA));
  assign bus.mem_wr     = live && (op == OP_STO);
endmodule

// File: tb/tb_ir_ctrl.sv
// Bench for ir_ctrl: PC model plus instruction memory,
// execution scoreboard and directed sequencing checks.
module tb_ir_ctrl;
  logic pclk;
  logic rst;
  logic [4:0] pc;
  logic [7:0] mem [32];

  ir_ctrl_if bus ();

  ir_ctrl dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [7:0] ir;
    logic       acc_ld;
    logic       mem_wr;
    logic       ldpc;
    logic [4:0] adir;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks;
  int   failures;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // PC model: load on ldpc, else increment
  always @(posedge pclk or negedge rst) begin
    if (!rst) pc <= '0;
    else if (bus.ldpc) pc <= bus.adir;
    else pc <= pc + 5'd1;
  end

  assign bus.adpc      = pc;
  assign bus.imem_data = mem[pc];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  // Monitor: compare every live execute slot
  always begin
    @(negedge pclk);
    #1;
    if (rst && bus.exec_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_exec actual=%0h expected=none",
                 bus.ir);
      end else begin
        mon_e = q.pop_front();
        chk("exec_slot",
            {bus.ir, bus.opcode, bus.operand,
             bus.acc_ld, bus.mem_wr, bus.ldpc, bus.adir},
            {mon_e.ir, mon_e.ir[7:5], mon_e.ir[4:0],
             mon_e.acc_ld, mon_e.mem_wr, mon_e.ldpc,
             mon_e.adir});
      end
    end
  end

  task automatic push(input logic [7:0] i,
                      input logic a, input logic w,
                      input logic l, input logic [4:0] d);
    exp_t e;
    e.ir = i; e.acc_ld = a; e.mem_wr = w;
    e.ldpc = l; e.adir = d;
    q.push_back(e);
  endtask

  task automatic tick;
    @(negedge pclk);
    #1;
  endtask

  function automatic logic [25:0] outs();
    return {bus.ir, bus.opcode, bus.operand,
            bus.exec_valid, bus.acc_ld, bus.mem_wr,
            bus.ldpc, bus.adir, bus.halted};
  endfunction

  task automatic clear_mem;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_pulse(input string name);
    #1;
    rst = 1'b0;
    #1;
    chk(name, 32'(outs()), 32'd0);
    q.delete();
    @(negedge pclk);
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_halt(input string name,
                           input int budget);
    int n;
    n = 0;
    while (!bus.halted && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    int seen;
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.resume   = 1'b0;
    bus.acc_zero = 1'b1;
    clear_mem();
    mem[0]     = 8'h45;
    mem[1]     = 8'hA6;
    mem[2]     = 8'hC7;
    mem[3]     = 8'hF4;
    mem[5'h14] = 8'h20;
    mem[5'h15] = 8'h82;
    mem[5'h16] = 8'h63;
    mem[5'h17] = 8'hE5;
    mem[5'h18] = 8'hC1;
    mem[5]     = 8'h00;
    mem[6]     = 8'h49;
    mem[7]     = 8'hE7;
    #3;
    chk("reset_outputs", 32'(outs()), 32'd0);
    push(8'h45, 1, 0, 0, 5'h00);
    push(8'hA6, 1, 0, 0, 5'h00);
    push(8'hC7, 0, 1, 0, 5'h00);
    push(8'hF4, 0, 0, 1, 5'h14);
    push(8'h20, 0, 0, 0, 5'h00);
    push(8'h63, 1, 0, 0, 5'h00);
    push(8'hE5, 0, 0, 1, 5'h05);
    push(8'h00, 0, 0, 1, 5'h06);
    push(8'h49, 1, 0, 0, 5'h00);
    push(8'hE7, 0, 0, 1, 5'h07);
    push(8'hE7, 0, 0, 1, 5'h07);
    push(8'hE7, 0, 0, 1, 5'h07);
    @(negedge pclk);
    rst = 1'b1;
    #1;
    chk("ev_before_edge", 32'(bus.exec_valid), 32'd0);
    tick();
    chk("first_exec", {bus.exec_valid, bus.ir},
        {1'b1, 8'h45});
    tick();
    tick();
    tick();
    chk("jmp_pulse", {bus.ldpc, bus.adir},
        {1'b1, 5'h14});
    tick();
    chk("jmp_bubble",
        {bus.exec_valid, bus.ldpc, bus.adir,
         bus.acc_ld, bus.mem_wr}, 32'd0);
    tick();
    chk("jmp_target", {bus.exec_valid, bus.ir},
        {1'b1, 8'h20});
    tick();
    chk("skz_squash",
        {bus.exec_valid, bus.acc_ld, bus.mem_wr,
         bus.ldpc}, 32'd0);
    tick();
    chk("skz_next", {bus.exec_valid, bus.ir},
        {1'b1, 8'h63});
    tick();
    tick();
    tick();
    chk("hlt_decode",
        {bus.exec_valid, bus.ldpc, bus.adir, bus.halted},
        {1'b1, 1'b1, 5'd6, 1'b0});
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold",
          {bus.halted, bus.ldpc, bus.adir, bus.adpc,
           bus.exec_valid},
          {1'b1, 1'b1, 5'd6, 5'd6, 1'b0});
      tick();
    end
    bus.resume = 1'b1;
    #1;
    chk("resume_ldpc", {bus.ldpc, bus.halted},
        {1'b0, 1'b1});
    tick();
    bus.resume = 1'b0;
    chk("resume_exec",
        {bus.exec_valid, bus.ir, bus.halted},
        {1'b1, 8'h49, 1'b0});
    seen = 0;
    n = 0;
    while (seen < 3 && n < 20) begin
      tick();
      n++;
      if (bus.exec_valid && bus.ir == 8'hE7) seen++;
    end
    chk("self_loop_jmps", seen, 3);
    #2;
    chk("q_drained_p1", q.size(), 0);
    reset_pulse("rst_mid_jmp");
    push(8'h45, 1, 0, 0, 5'h00);
    push(8'hA6, 1, 0, 0, 5'h00);
    tick();
    tick();
    chk("restart_pc", 32'(bus.adpc), 32'd2);
    #2;
    chk("q_drained_restart", q.size(), 0);

    clear_mem();
    mem[0] = 8'h45;
    mem[1] = 8'hA6;
    mem[2] = 8'h20;
    mem[3] = 8'h82;
    mem[4] = 8'hC7;
    mem[5] = 8'h00;
    bus.acc_zero = 1'b1;
    reset_pulse("rst_p2a");
    push(8'h45, 1, 0, 0, 5'h00);
    push(8'hA6, 1, 0, 0, 5'h00);
    push(8'h20, 0, 0, 0, 5'h00);
    push(8'hC7, 0, 1, 0, 5'h00);
    push(8'h00, 0, 0, 1, 5'h06);
    wait_halt("skz_taken_halt", 15);
    #2;
    chk("q_drained_skz1", q.size(), 0);
    bus.acc_zero = 1'b0;
    reset_pulse("rst_in_halt");
    push(8'h45, 1, 0, 0, 5'h00);
    push(8'hA6, 1, 0, 0, 5'h00);
    push(8'h20, 0, 0, 0, 5'h00);
    push(8'h82, 1, 0, 0, 5'h00);
    push(8'hC7, 0, 1, 0, 5'h00);
    push(8'h00, 0, 0, 1, 5'h06);
    wait_halt("skz_not_taken_halt", 15);
    #2;
    chk("q_drained_skz0", q.size(), 0);

    clear_mem();
    mem[0]  = 8'hFE;
    mem[30] = 8'h41;
    mem[31] = 8'h00;
    reset_pulse("rst_p3");
    push(8'hFE, 0, 0, 1, 5'd30);
    push(8'h41, 1, 0, 0, 5'h00);
    push(8'h00, 0, 0, 1, 5'd0);
    wait_halt("wrap_halt", 10);
    chk("wrap_hold",
        {bus.ldpc, bus.adir, bus.adpc},
        {1'b1, 5'd0, 5'd0});
    tick();
    chk("wrap_hold2",
        {bus.halted, bus.ldpc, bus.adir, bus.adpc},
        {1'b1, 1'b1, 5'd0, 5'd0});
    #2;
    chk("q_drained_wrap", q.size(), 0);

    clear_mem();
    mem[0]  = 8'hFF;
    mem[31] = 8'hE3;
    mem[3]  = 8'h00;
    reset_pulse("rst_p4");
    push(8'hFF, 0, 0, 1, 5'd31);
    push(8'hE3, 0, 0, 1, 5'd3);
    push(8'h00, 0, 0, 1, 5'd4);
    wait_halt("jmp31_halt", 12);
    chk("jmp31_adir", {bus.ldpc, bus.adir, bus.adpc},
        {1'b1, 5'd4, 5'd4});
    #2;
    chk("q_drained_jmp31", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
